pulse_tx: RTL

//   Transmit side of the single-wire pulse link. Accepts pulse requests over a

---
 rtl/pulse_tx_pkg.sv | 21 ++
 rtl/pulse_tx_timer.sv | 33 +++
 rtl/pulse_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pulse_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_tx_pkg
// Purpose  : Shared state encoding and timing constants for the pulse link.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_e;

    // Receiver agreement-filter depth; every transmitted level must last at least this long.
    localparam int c_RX_FILTER_DEPTH = 3;
    localparam int c_MIN_PULSE_DEF   = c_RX_FILTER_DEPTH;
    localparam int c_GAP_CYCLES_DEF  = c_RX_FILTER_DEPTH;

endpackage
`default_nettype wire

// File: rtl/pulse_tx_timer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_tx_timer
// Purpose  : Loadable down-counter with zero flag; load has priority over decrement.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_tx_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : pulse_tx
// Purpose  : Pulse-link transmitter: handshake-accepted pulses of clamped width
//            followed by an enforced low gap. Macro PULSE_TX_COUNT_EN adds
//            the o_pulse_count accepted-request counter.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_tx
    import pulse_tx_pkg::*;
#(
    parameter int LEN_BITS   = 8,
    parameter int MIN_PULSE  = c_MIN_PULSE_DEF,
    parameter int GAP_CYCLES = c_GAP_CYCLES_DEF
`ifdef PULSE_TX_COUNT_EN
    ,
    parameter int CNT_BITS   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    input  logic [LEN_BITS-1:0] i_req_len,
    output logic                o_req_ready,
    output logic                o_out_data,
    output logic                o_busy
`ifdef PULSE_TX_COUNT_EN
    ,
    output logic [CNT_BITS-1:0] o_pulse_count
`endif
);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_HIGH = HIGH;
    localparam logic [1:0] c_ST_GAP  = GAP;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_out_data;
    logic                w_xfer;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;
    logic [LEN_BITS-1:0] w_eff_len;
    logic [LEN_BITS-1:0] w_load_val;

    assign o_req_ready = (r_state == c_ST_IDLE) && !rst;
    assign o_busy      = (r_state != c_ST_IDLE);
    assign o_out_data  = r_out_data;
    assign w_xfer      = i_req_valid && o_req_ready;

    // Requests shorter than the far-end filter depth are stretched, including zero.
    assign w_eff_len = (i_req_len < LEN_BITS'(MIN_PULSE)) ? LEN_BITS'(MIN_PULSE) : i_req_len;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_load_val  = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = c_ST_HIGH;
                    w_load      = 1'b1;
                    w_load_val  = w_eff_len - LEN_BITS'(1);
                end
            end
            c_ST_HIGH: begin
                if (w_zero) begin
                    w_state_nxt = c_ST_GAP;
                    w_load      = 1'b1;
                    w_load_val  = LEN_BITS'(GAP_CYCLES - 1);
                end else begin
                    w_dec = 1'b1;
                end
            end
            c_ST_GAP: begin
                if (w_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_out_data <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_data <= (w_state_nxt == c_ST_HIGH);
        end
    end

    pulse_tx_timer #(
        .WIDTH (LEN_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

`ifdef PULSE_TX_COUNT_EN
    logic [CNT_BITS-1:0] r_pulse_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_count <= '0;
        end else if (w_xfer) begin
            r_pulse_count <= r_pulse_count + CNT_BITS'(1);
        end
    end

    assign o_pulse_count = r_pulse_count;
`endif

endmodule
`default_nettype wire
